// File: rtl/seq_muldiv_alu_pkg.sv
// Shared ALU control definitions: legacy ALU codes plus the RV32M
// multiply/divide op codes and sequencer state encoding.
package seq_muldiv_alu_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/seq_muldiv_alu_cond_negate.sv
// Conditional two's-complement negation: out = sign ? -in : in.
module cond_negate
    import seq_muldiv_alu_pkg::*;
#(
    parameter int W = XLEN_DEF
) (
    input  logic [W-1:0] in,
    input  logic         sign,
    output logic [W-1:0] out
);

    assign out = sign ? (~in + W'(1)) : in;

endmodule

// File: rtl/seq_muldiv_alu.sv
// Sequential RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on magnitudes, sign fixed up at the end.
module seq_muldiv_alu
    import seq_muldiv_alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int OP_BITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_BITS-1:0] op,
    input  logic [XLEN-1:0]    rdata1,
    input  logic [XLEN-1:0]    rdata2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state, state_nx;

    logic [2:0]      op_q;
    logic            neg_a, neg_b;
    logic [XLEN-1:0] hi, lo, b_q, res_q;
    logic [CW-1:0]   cnt;

    // Request decode
    logic [2:0]      op_in;
    logic            a_signed, b_signed, sa, sb, div_zero, div_ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag;

    assign op_in    = op[2:0];
    assign a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
    assign b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign sa       = a_signed && rdata1[XLEN-1];
    assign sb       = b_signed && rdata2[XLEN-1];
    assign div_zero = op_in[2] && (rdata2 == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (rdata1 == INT_MIN) && (rdata2 == '1);
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    cond_negate #(.W(XLEN)) u_mag_a (.in(rdata1), .sign(sa), .out(a_mag));
    cond_negate #(.W(XLEN)) u_mag_b (.in(rdata2), .sign(sb), .out(b_mag));

    // Iteration datapath: hi holds product-high / partial remainder,
    // lo holds multiplier / dividend shifting out as quotient shifts in.
    logic [XLEN:0] mul_sum, div_sh, div_diff;
    logic          div_ge;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ge   = !div_diff[XLEN];

    // Sign correction
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, fix_res;
    logic              div_sign;

    assign div_raw  = op_q[1] ? hi : lo;
    assign div_sign = op_q[1] ? neg_a : (neg_a ^ neg_b);

    cond_negate #(.W(2*XLEN)) u_fix_prod (.in({hi, lo}), .sign(neg_a ^ neg_b), .out(prod_fix));
    cond_negate #(.W(XLEN))   u_fix_div  (.in(div_raw), .sign(div_sign), .out(div_fix));

    always_comb begin
        fix_res = div_fix;
        if (!op_q[2])
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) begin
                if (div_zero || div_ovf) state_nx = DONE;
                else if (op_in[2])       state_nx = DIV;
                else                     state_nx = MUL;
            end
            MUL, DIV: if (cnt == CW'(1)) state_nx = FIX;
            FIX:      state_nx = DONE;
            DONE:     if (out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            res_q <= '0;
            cnt   <= '0;
        end else if (!flush) begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q  <= op_in;
                    neg_a <= sa;
                    neg_b <= sb;
                    hi    <= '0;
                    lo    <= a_mag;
                    b_q   <= b_mag;
                    cnt   <= CNT_INIT;
                    if (div_zero)     res_q <= op_in[1] ? rdata1 : '1;
                    else if (div_ovf) res_q <= op_in[1] ? '0 : rdata1;
                end
                MUL: begin
                    {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
                    cnt      <= cnt - CW'(1);
                end
                DIV: begin
                    hi  <= div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                    lo  <= {lo[XLEN-2:0], div_ge};
                    cnt <= cnt - CW'(1);
                end
                FIX:     res_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign out_valid = (state == DONE);
    assign result    = out_valid ? res_q : '0;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed bench for seq_muldiv_alu: per-cycle compare against an
// arithmetic transaction model plus hand-computed literal expectations.
module tb_seq_muldiv_alu;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] rdata1, rdata2, result;

    int errors = 0;
    int checks = 0;

    seq_muldiv_alu #(.XLEN(32), .OP_BITS(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rdata1(rdata1), .rdata2(rdata2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // RV32M semantics from plain wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ubs, sp;
        logic [63:0] up;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ubs = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = sa * sb;                 return sp[63:32]; end
            3'd2: begin sp = sa * ubs;                return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_short(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) ||
               ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model of the handshake
    bit          started = 0, m_busy = 0, m_done = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            started = 1; m_busy = 0; m_done = 0;
        end else if (started) begin
            if (flush) begin
                m_busy = 0; m_done = 0;
            end else if (m_done) begin
                if (out_ready) m_done = 0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
            end else if (in_valid) begin
                m_res = ref_model(op, rdata1, rdata2);
                if (is_short(op, rdata1, rdata2)) m_done = 1;
                else begin m_busy = 1; m_left = 33; end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, !m_busy && !m_done});
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_done});
            chk("cyc_result", result, m_done ? m_res : 32'h0);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit lit, input int hold);
        int n;
        @(negedge clk);
        out_ready = (hold == 0);
        in_valid = 1'b1; op = o; rdata1 = a; rdata2 = b;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
        if (lit) begin
            chk("lit_result", result, exp);
            chk("lit_latency", 32'(n), 32'(lat));
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_result", result, exp);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("ready_after_done", {31'b0, in_ready}, 32'd1);
            chk("result_after_done", result, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rdata1 = '0; rdata2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", result, 32'h0);

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34, 1, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, 1, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, 1, 0);
        run_op(3'd5, 32'd100,        32'd7,          32'd14,        34, 1, 0);
        run_op(3'd7, 32'd100,        32'd7,          32'd2,         34, 1, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         34, 1, 0);
        run_op(3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34, 1, 0);
        // Short paths: divide by zero and signed overflow
        run_op(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1, 1, 0);
        run_op(3'd7, 32'd5,          32'd0,          32'd5,         1, 1, 0);
        run_op(3'd4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 1, 1, 0);
        run_op(3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 1, 1, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, 1, 0);
        // Overflow pattern is not special for the unsigned forms
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, 1, 0);
        // Back-pressure: result held for 5 cycles
        run_op(3'd0, 32'd3,          32'd5,          32'd15,        34, 1, 5);
        // Model-only operands
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 0, 0, 0);
        run_op(3'd1, 32'h8765_4321, 32'h1357_9BDF, 32'h0, 0, 0, 0);
        run_op(3'd2, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        run_op(3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0, 0, 0, 0);
        run_op(3'd6, 32'h8000_0000, 32'd7,          32'h0, 0, 0, 0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'h0001_0003, 32'h0, 0, 0, 0);

        // Flush during a divide
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; rdata1 = 32'hFFFF_FFF9; rdata2 = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            chk("flush_no_valid", {31'b0, out_valid}, 32'd0);
        end

        // Reset during a multiply
        in_valid = 1'b1; op = 3'd0; rdata1 = 32'd9; rdata2 = 32'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'h0);
        repeat (40) begin
            @(negedge clk);
            chk("rst_no_valid", {31'b0, out_valid}, 32'd0);
        end

        // Unit still works after flush and reset
        run_op(3'd0, 32'd6, 32'd7, 32'd42, 34, 1, 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
